// File: rtl/pipa_responder.sv
// PIPA interrogation responder: synchronizes PIPASW/PIPDAT, drains one count per
// non-zero axis accumulator per interrogation, and answers with active-low pulses.
module pipa_responder #(
  parameter int PULSE_W = 4,
  parameter int ARM_TO  = 64
) (
  input  logic               SIM_CLK,
  input  logic               SIM_RST,
  input  logic               PIPASW,
  input  logic               PIPDAT,
  input  logic               LD_VALID,
  input  logic [1:0]         LD_AXIS,
  input  logic signed [14:0] LD_COUNT,
  output logic               LD_READY,
  output logic               PIPAXP_n,
  output logic               PIPAXM_n,
  output logic               PIPAYP_n,
  output logic               PIPAYM_n,
  output logic               PIPAZP_n,
  output logic               PIPAZM_n,
  output logic signed [14:0] PEND_X,
  output logic signed [14:0] PEND_Y,
  output logic signed [14:0] PEND_Z,
  output logic [7:0]         MISSED
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PULSE} state_t;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [7:0]          miss_q, miss_d;
  logic signed [14:0]  acc_q [3];
  logic signed [14:0]  acc_d [3];
  logic                p_n_q [3];
  logic                p_n_d [3];
  logic                m_n_q [3];
  logic                m_n_d [3];
  logic                sw_s1_q, sw_s2_q, sw_prev_q;
  logic                dat_s1_q, dat_s2_q, dat_prev_q;
  logic                sw_rise, dat_rise, miss_inc;

  function automatic logic signed [14:0] sat_add15(input logic signed [14:0] a,
                                                   input logic signed [14:0] b);
    logic signed [15:0] sum;
    sum = $signed({a[14], a}) + $signed({b[14], b});
    if (sum > 16'sd16383)
      return 15'h3FFF;
    else if (sum < -16'sd16384)
      return 15'h4000;
    else
      return sum[14:0];
  endfunction

  assign sw_rise  = sw_s2_q && !sw_prev_q;
  assign dat_rise = dat_s2_q && !dat_prev_q;
  assign LD_READY = (state_q == S_IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    miss_d   = miss_q;
    miss_inc = 1'b0;
    acc_d    = acc_q;
    p_n_d    = p_n_q;
    m_n_d    = m_n_q;

    case (state_q)
      S_IDLE: begin
        // A simultaneous PIPDAT rise loses to PIPASW and is booked as missed.
        if (dat_rise) miss_inc = 1'b1;
        if (sw_rise) begin
          state_d = S_ARMED;
          cnt_d   = 16'(ARM_TO);
        end
        if (LD_VALID) begin
          for (int i = 0; i < 3; i++) begin
            if (LD_AXIS == i[1:0]) acc_d[i] = sat_add15(acc_q[i], LD_COUNT);
          end
        end
      end
      S_ARMED: begin
        if (dat_rise) begin
          state_d = S_PULSE;
          cnt_d   = 16'(PULSE_W);
          for (int i = 0; i < 3; i++) begin
            if (acc_q[i][14]) begin
              m_n_d[i] = 1'b0;
              acc_d[i] = acc_q[i] + 15'sd1;
            end else if (acc_q[i] != 15'sd0) begin
              p_n_d[i] = 1'b0;
              acc_d[i] = acc_q[i] - 15'sd1;
            end
          end
        end else if (sw_rise) begin
          cnt_d = 16'(ARM_TO);
        end else if (cnt_q == 16'd1) begin
          state_d  = S_IDLE;
          miss_inc = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_PULSE: begin
        if (dat_rise) miss_inc = 1'b1;
        if (cnt_q == 16'd1) begin
          state_d = S_IDLE;
          for (int i = 0; i < 3; i++) begin
            p_n_d[i] = 1'b1;
            m_n_d[i] = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (miss_inc && (miss_q != 8'hFF)) miss_d = miss_q + 8'd1;
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      miss_q     <= '0;
      sw_s1_q    <= 1'b0;
      sw_s2_q    <= 1'b0;
      sw_prev_q  <= 1'b0;
      dat_s1_q   <= 1'b0;
      dat_s2_q   <= 1'b0;
      dat_prev_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        acc_q[i] <= '0;
        p_n_q[i] <= 1'b1;
        m_n_q[i] <= 1'b1;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      miss_q     <= miss_d;
      sw_s1_q    <= PIPASW;
      sw_s2_q    <= sw_s1_q;
      sw_prev_q  <= sw_s2_q;
      dat_s1_q   <= PIPDAT;
      dat_s2_q   <= dat_s1_q;
      dat_prev_q <= dat_s2_q;
      for (int i = 0; i < 3; i++) begin
        acc_q[i] <= acc_d[i];
        p_n_q[i] <= p_n_d[i];
        m_n_q[i] <= m_n_d[i];
      end
    end
  end

  assign PIPAXP_n = p_n_q[0];
  assign PIPAXM_n = m_n_q[0];
  assign PIPAYP_n = p_n_q[1];
  assign PIPAYM_n = m_n_q[1];
  assign PIPAZP_n = p_n_q[2];
  assign PIPAZM_n = m_n_q[2];
  assign PEND_X   = acc_q[0];
  assign PEND_Y   = acc_q[1];
  assign PEND_Z   = acc_q[2];
  assign MISSED   = miss_q;

endmodule

// File: doc/pipa_responder.md
# pipa_responder

IMU-side responder for the PIPA interrogation interface. Receives the PIPASW and PIPDAT interrogation pulses and answers with per-axis plus/minus PIPA pulses, exactly as the accelerometer loop returns them to the AGC counter inputs. Each axis holds a signed pending-increment accumulator loaded by the simulation test harness. Every valid interrogation drains one count per non-zero axis. The block sits in the simulation environment, outside the AGC module tree, facing the PIPA outputs of the AGC's input/output logic.

## Interface
- PULSE_W, 4: width of each PIPA answer pulse in SIM_CLK cycles (1..255).
- ARM_TO, 64: cycles ARMED waits for PIPDAT before abandoning the interrogation (1..65535).
- SIM_CLK  in  1  sole clock; all state on rising edge.
- SIM_RST  in  1  asynchronous, active-low reset.
- PIPASW  in  1  interrogation switch pulse, asynchronous to SIM_CLK, active high.
- PIPDAT  in  1  interrogation data pulse, asynchronous, active high.
- LD_VALID  in  1  harness load request.
- LD_AXIS  in  2  axis to load: 0=X, 1=Y, 2=Z, 3=ignored (accepted, no effect).
- LD_COUNT  in  15  signed increment added to the selected accumulator.
- LD_READY  out  1  load accepted on the cycle where LD_VALID && LD_READY.
- PIPAXP_n, PIPAXM_n, PIPAYP_n, PIPAYM_n, PIPAZP_n, PIPAZM_n  out  1 each  active-low plus/minus pulses, registered.
- PEND_X, PEND_Y, PEND_Z  out  15 each  signed accumulator contents.
- MISSED  out  8  saturating count of PIPDAT rises seen outside ARMED, plus ARM_TO expiries.

## Operation
- PIPASW and PIPDAT each pass through a 2-flop synchronizer. A third flop provides rising-edge detection: rise = sync2 && !prev.
- The state machine has three states: IDLE, ARMED and PULSE.
- IDLE -> ARMED on a PIPASW rise. The timeout counter loads ARM_TO.
- ARMED -> PULSE on a PIPDAT rise. Action on this transition, per axis:
  - accumulator > 0: assert the P output and decrement by 1;
  - accumulator < 0: assert the M output and increment by 1;
  - accumulator == 0: assert no output.
  - The pulse counter loads PULSE_W.
- ARMED -> IDLE when the timeout counter reaches 0 without a PIPDAT rise. MISSED increments.
- In ARMED, a repeated PIPASW rise reloads the timeout and keeps the state ARMED.
- PULSE -> IDLE after PULSE_W cycles. All outputs return high on the same edge.
- PIPDAT rise in IDLE or PULSE: no pulse, MISSED increments. PIPASW rise in PULSE is ignored.
- If PIPASW and PIPDAT rises are detected on the same cycle in IDLE, the PIPASW rise is taken. The PIPDAT rise counts toward MISSED.
- LD_READY = (state == IDLE). An accepted load adds LD_COUNT to the selected accumulator with signed saturation at +16383 / -16384. The value -16384 is reachable only by saturation or a direct load.
- Accumulator width is 15 bits signed. The internal sum is 16 bits, then clamped.
- MISSED saturates at 255 and never wraps.
- No P and M output for the same axis are ever low together.

## Timing
- Reset (SIM_RST low, asynchronous) sets:
  - state IDLE; all pulse outputs 1; LD_READY 1;
  - PEND_* 0; MISSED 0; synchronizers and edge flops 0.
- Reset mid-PULSE: outputs go high immediately, without waiting for a clock edge.
- Input latency: let edge 1 be the first SIM_CLK edge that samples the input high. The edge is detected after edge 2. The state changes, and outputs go low, at edge 3.
- Pulse length: outputs are low for exactly PULSE_W cycles. PEND_* updates on the same edge the outputs fall.
- Timeout: entering ARMED at edge n with no PIPDAT rise means IDLE at edge n+ARM_TO, with MISSED updated on that edge.
- Loads: the accumulator updates on the edge where LD_VALID && LD_READY. The new value is visible on PEND_* the next cycle.
- Minimum input pulse width is 2 SIM_CLK cycles. Shorter pulses may be missed.

## Test plan
- Reset, then load X=+3, Y=-2, Z=0, then issue 3 PIPASW->PIPDAT pairs.
  - Required: XP low 3 times, 4 cycles each; YM low 2 times; Z silent.
  - Final PEND = 0, 0, 0. MISSED = 0.
- PIPDAT rise with no preceding PIPASW -> no pulses, MISSED = 1. Repeat 300 times -> MISSED = 255.
- PIPASW only, then wait ARM_TO cycles -> returns to IDLE at entry+64, MISSED = 1, LD_READY high again.
- Load X=+16000, then X=+1000 -> PEND_X = 16383. Load X=-16384 twice from 0 -> PEND_X = -16384.
- Assert SIM_RST low during PULSE with XP low -> XP_n high with no clock edge. After release, PEND_X = 0 and state IDLE.
- Attempt a load while ARMED (LD_VALID held) -> not accepted until IDLE. Accepted on the first IDLE cycle; PEND reflects the single add.
